// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial product per clock, unsigned or
// two's-complement operands, start/done handshake, product held until next done.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   step;
  logic [2*WIDTH:0]   step_sh;

  // The most negative operand maps to 2^(WIDTH-1), which still fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic            is_signed);
    logic [WIDTH-1:0] neg;
    neg = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    return (is_signed && v[WIDTH-1]) ? neg : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    product_d = product_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;

    sum     = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
    step    = mplier_q[0] ? {sum, acc_q[WIDTH-1:0]} : acc_q;
    step_sh = step >> 1;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = magnitude(a, signed_mode);
          mplier_d = magnitude(b, signed_mode);
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d    = step_sh;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        // Final bit: publish the completed accumulator on the same edge.
        if (count_q == CW'(WIDTH-1)) begin
          state_d   = DONE;
          product_d = neg_q ? negate(step_sh[2*WIDTH-1:0]) : step_sh[2*WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    neg_q    <= neg_d;
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: WIDTH=2 exhaustive unsigned, WIDTH=8 vector table,
// plus hand-written start-during-run, mid-run reset and back-to-back sequences.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] product8;

  logic        start2 = 1'b0, sm2 = 1'b0;
  logic [1:0]  a2 = '0, b2 = '0;
  logic        busy2, done2;
  logic [3:0]  product2;

  int checks = 0;
  int errors = 0;
  int both_high = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8)
  );

  seq_multiplier #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .product(product2)
  );

  always @(negedge clk) begin
    if ((busy8 && done8) || (busy2 && done2)) both_high++;
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mul8(input logic [7:0] ta, input logic [7:0] tb, input logic tsm,
                      output logic [15:0] p, output int lat, output int nbusy);
    @(negedge clk);
    a8 = ta; b8 = tb; sm8 = tsm; start8 = 1'b1;
    lat = -1; nbusy = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (busy8) nbusy++;
      if (done8) begin
        lat = c;
        break;
      end
    end
    p = product8;
  endtask

  task automatic mul2(input logic [1:0] ta, input logic [1:0] tb,
                      output logic [3:0] p, output int lat);
    @(negedge clk);
    a2 = ta; b2 = tb; sm2 = 1'b0; start2 = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (done2) begin
        lat = c;
        break;
      end
    end
    p = product2;
  endtask

  initial begin
    logic [15:0] p8;
    logic [3:0]  p2;
    int lat, nbusy, cyc, ndone, first_done, second_done, hold_bad;
    logic [3:0] exp2;

    tbl[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[1]  = '{8'h00, 8'hC8, 1'b0, 16'h0000};
    tbl[2]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
    tbl[3]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[4]  = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    tbl[5]  = '{8'h0A, 8'h14, 1'b0, 16'h00C8};
    tbl[6]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
    tbl[7]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    tbl[8]  = '{8'h80, 8'h01, 1'b1, 16'hFF80};
    tbl[9]  = '{8'h05, 8'hFD, 1'b0, 16'h04F1};
    tbl[10] = '{8'h06, 8'h07, 1'b0, 16'h002A};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    chk("rst_product8", {16'd0, product8}, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    chk("rst_product2", {28'd0, product2}, 32'd0);

    // WIDTH=2 exhaustive unsigned
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        exp2 = 4'(ia * ib);
        mul2(2'(ia), 2'(ib), p2, lat);
        chk($sformatf("w2_prod_%0dx%0d", ia, ib), {28'd0, p2}, {28'd0, exp2});
        chk($sformatf("w2_lat_%0dx%0d", ia, ib), lat, 32'd3);
      end
    end

    // WIDTH=8 vector table
    for (int i = 0; i < 11; i++) begin
      mul8(tbl[i].a, tbl[i].b, tbl[i].sm, p8, lat, nbusy);
      chk($sformatf("w8_prod_%0d", i), {16'd0, p8}, {16'd0, tbl[i].exp});
      chk($sformatf("w8_lat_%0d", i), lat, 32'd9);
      chk($sformatf("w8_busycyc_%0d", i), nbusy, 32'd8);
    end

    // Start pulsed during RUN must be ignored
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd20; sm8 = 1'b0; start8 = 1'b1;
    ndone = 0; first_done = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start8 = (c == 4);
      if (c == 4) begin a8 = 8'd99; b8 = 8'd99; end
      if (done8) begin
        ndone++;
        if (first_done < 0) begin
          first_done = c;
          p8 = product8;
        end
      end
    end
    chk("srun_product", {16'd0, p8}, 32'h00C8);
    chk("srun_lat", first_done, 32'd9);
    chk("srun_ndone", ndone, 32'd1);
    chk("srun_idle_busy", {31'd0, busy8}, 32'd0);

    // Reset in the 3rd busy cycle
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd20; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mrst_busy_before", {31'd0, busy8}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", {31'd0, busy8}, 32'd0);
    chk("mrst_done", {31'd0, done8}, 32'd0);
    chk("mrst_product", {16'd0, product8}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    chk("mrst_no_done", ndone, 32'd0);
    mul8(8'd6, 8'd7, 1'b0, p8, lat, nbusy);
    chk("mrst_after_prod", {16'd0, p8}, 32'd42);
    chk("mrst_after_lat", lat, 32'd9);

    // Back-to-back with start held high
    @(negedge clk);
    a8 = 8'd12; b8 = 8'd12; sm8 = 1'b0; start8 = 1'b1;
    first_done = -1; second_done = -1; hold_bad = 0; cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      cyc = c;
      if (c == 1) begin a8 = 8'd9; b8 = 8'hFF; sm8 = 1'b1; end
      if (done8 && first_done < 0) begin
        first_done = c;
        chk("b2b_first_prod", {16'd0, product8}, 32'h0090);
      end else if (first_done > 0 && c == first_done + 1) begin
        start8 = 1'b0;
        chk("b2b_no_gap_busy", {31'd0, busy8}, 32'd1);
      end
      if (first_done > 0 && c > first_done && !done8 && product8 !== 16'h0090) hold_bad++;
      if (done8 && first_done > 0 && c > first_done) begin
        second_done = c;
        chk("b2b_second_prod", {16'd0, product8}, 32'hFFF7);
        break;
      end
    end
    start8 = 1'b0;
    chk("b2b_first_lat", first_done, 32'd9);
    chk("b2b_spacing", second_done - first_done, 32'd9);
    chk("b2b_hold", hold_bad, 32'd0);

    chk("busy_done_exclusive", both_high, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier, the multi-cycle, width-generic successor to the team's 2-bit combinational multiplier. It accepts two WIDTH-bit operands on a start/done handshake and computes one partial product per clock. It supports unsigned and two's-complement signed modes. It sits in the arithmetic datapath wherever a full array multiplier costs too much area.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk
- start  input  1  request; sampled only when the block is ready (IDLE or DONE)
- signed_mode  input  1  0 = unsigned operands, 1 = two's-complement operands; captured with start
- a  input  WIDTH  multiplicand; captured with start
- b  input  WIDTH  multiplier; captured with start
- busy  output  1  high while a multiplication is in progress (RUN)
- done  output  1  one-cycle pulse, product valid
- product  output  2*WIDTH  result; holds its value until the next done

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE or DONE with start=1: latch signed_mode, a and b, clear the accumulator, set count=0, go to RUN.
  - Signed mode: operands are converted to magnitudes on capture. A sign flag is stored as a[WIDTH-1] XOR b[WIDTH-1].
  - Magnitude of the most negative value (2^(WIDTH-1)) fits in WIDTH unsigned bits. No extra bit is needed.
- RUN, each cycle:
  - If the multiplier LSB is 1, add the multiplicand magnitude into the upper half of the 2*WIDTH+1-bit accumulator.
  - Shift the accumulator right by 1, then increment count.
  - When count reaches WIDTH-1, go to DONE on the next edge.
- Entry to DONE: write product = accumulator, or its two's-complement negation if signed_mode and the sign flag are both 1.
- DONE with start=0: go to IDLE. DONE with start=1: accept the new operands (back-to-back).
- RUN ignores start entirely. Operands and signed_mode are not re-sampled.
- Arithmetic rules:
  - Unsigned results are exact for all inputs.
  - Signed results are exact for all inputs, including (-2^(WIDTH-1))*(-2^(WIDTH-1)) = +2^(2*WIDTH-2).
  - There is no overflow condition.
- Reset at any time (including mid-RUN): on the next edge go to IDLE, busy=0, done=0, product=0, accumulator cleared. Any in-flight result is discarded and no done is produced.
- rst has priority over start on the same edge.

## Timing
- Reset values: busy=0, done=0, product=0.
- Let the start-sampling edge be E0.
- busy is 1 in the cycles following edges E0 through E(WIDTH-1), i.e. exactly WIDTH cycles.
- At edge E(WIDTH):
  - busy=0, done=1 for exactly one cycle.
  - product takes the new value and holds it until the next done.
- Latency from sampling start to done high is WIDTH+1 edges.
- Throughput with back-to-back start (start held high):
  - One result every WIDTH+1 cycles.
  - done and the next busy are adjacent, with no IDLE gap.
- busy and done are never high together.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=2 exhaustive, unsigned: all 16 {a,b} combinations. Each product must equal a*b, e.g. 3*3 -> product=4'b1001. done must arrive exactly 3 edges after start.
- WIDTH=8, unsigned:
  - 255*255 -> product=16'hFE01.
  - 0*200 -> product=16'h0000.
  - busy high for exactly 8 cycles, then done high for one cycle.
- WIDTH=8, signed:
  - -3*5 (8'hFD, 8'h05) -> product=16'hFFF1.
  - -128*-128 (8'h80, 8'h80) -> product=16'h4000.
  - 127*-128 -> product=16'hC080.
- Start during RUN: pulse start with new operands at the 4th busy cycle of 10*20. The result must still be 200 (16'h00C8), with a single done and no extra request queued.
- Reset mid-RUN: assert rst in the 3rd busy cycle.
  - Next cycle: busy=0, done=0, product=0.
  - No done pulse follows.
  - A subsequent 6*7 must give 42 with normal latency.
- Back-to-back: hold start high with 12*12 and then 9*-1 signed.
  - Results are 16'h0090, then 16'hFFF7.
  - done pulses are 9 cycles apart, and product holds between pulses.
